// File: rtl/mem_region_ctrl_if.sv
// IO device request/response handshake between the region controller and the MMIO block.
interface mem_region_ctrl_if;
  logic io_req_valid;
  logic io_req_we;
  logic io_req_ready;
  logic io_rsp_valid;

  modport master (output io_req_valid, output io_req_we,
                  input  io_req_ready, input  io_rsp_valid);
  modport slave  (input  io_req_valid, input  io_req_we,
                  output io_req_ready, output io_rsp_valid);
endinterface

// File: rtl/mem_region_ctrl.sv
// Memory-region decode for the 3-stage core: BIOS/IMEM/DMEM write enables, M-stage load selects,
// and a stalling multi-cycle MMIO handshake guarded by a timeout watchdog.
module mem_region_ctrl #(
  parameter int                 WEA_W         = 4,
  parameter int                 TAG_W         = 4,
  parameter logic [TAG_W-1:0]   DMEM_TAG_MASK = 4'b1101,
  parameter logic [TAG_W-1:0]   IMEM_TAG_MASK = 4'b1110,
  parameter logic [TAG_W-1:0]   BIOS_TAG      = 4'b0100,
  parameter logic [TAG_W-1:0]   IO_TAG        = 4'b1000,
  parameter int                 IO_TIMEOUT    = 255,
  parameter int                 TO_W          = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid,
  input  logic               ex_load,
  input  logic [WEA_W-1:0]   ex_wea,
  input  logic [TAG_W-1:0]   ex_pc_tag,
  input  logic [TAG_W-1:0]   ex_adr_tag,
  output logic [WEA_W-1:0]   iwea,
  output logic [WEA_W-1:0]   dwea,
  mem_region_ctrl_if.master  io,
  output logic               iload_sel,
  output logic [1:0]         dload_sel,
  output logic               stall,
  output logic               io_timeout,
  output logic               io_err
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t            state, state_next;
  logic [TO_W-1:0]   cnt;
  logic              cnt_clr;
  logic              we_q;
  logic [TAG_W-1:0]  pc_tag_m, adr_tag_m;
  logic              io_err_q;

  logic st, io_acc, dmem_hit, imem_hit, last_cycle;
  logic req_valid_c, req_we_c, stall_c, timeout_c;

  assign st         = (ex_wea != '0);
  assign io_acc     = ex_valid & (ex_adr_tag == IO_TAG) & (ex_load | st);
  assign dmem_hit   = ((ex_adr_tag & DMEM_TAG_MASK) == TAG_W'(1));
  assign imem_hit   = ((ex_adr_tag & IMEM_TAG_MASK) == TAG_W'(2));
  assign last_cycle = (cnt == TO_W'(IO_TIMEOUT - 1));

  always_comb begin
    state_next  = state;
    req_valid_c = 1'b0;
    req_we_c    = we_q;
    stall_c     = 1'b0;
    timeout_c   = 1'b0;
    cnt_clr     = 1'b0;
    case (state)
      IDLE: begin
        req_valid_c = io_acc;
        req_we_c    = st;
        if (io_acc) begin
          if (io.io_req_ready) begin
            if (!st) begin
              state_next = RSP;
              stall_c    = 1'b1;
              cnt_clr    = 1'b1;
            end
          end else begin
            state_next = REQ;
            stall_c    = 1'b1;
            cnt_clr    = 1'b1;
          end
        end
      end
      REQ: begin
        req_valid_c = 1'b1;
        if (io.io_req_ready) begin
          if (we_q) begin
            state_next = IDLE;
          end else begin
            state_next = RSP;
            stall_c    = 1'b1;
            cnt_clr    = 1'b1;
          end
        end else if (last_cycle) begin
          state_next = IDLE;
          timeout_c  = 1'b1;
        end else begin
          stall_c = 1'b1;
        end
      end
      RSP: begin
        if (io.io_rsp_valid) begin
          state_next = IDLE;
        end else if (last_cycle) begin
          state_next = IDLE;
          timeout_c  = 1'b1;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      pc_tag_m  <= '0;
      adr_tag_m <= '0;
      io_err_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (cnt_clr)
        cnt <= '0;
      else if (state != IDLE)
        cnt <= cnt + TO_W'(1);
      if (state == IDLE)
        we_q <= st;
      if (!stall_c) begin
        pc_tag_m  <= ex_pc_tag;
        adr_tag_m <= ex_adr_tag;
      end
      if (timeout_c)
        io_err_q <= 1'b1;
    end
  end

  // Everything combinational is forced quiet while reset is held.
  assign io.io_req_valid = rst & req_valid_c;
  assign io.io_req_we    = rst & req_we_c;
  assign stall           = rst & stall_c;
  assign io_timeout      = rst & timeout_c;
  assign io_err          = io_err_q;

  assign dwea = (rst && ex_valid && dmem_hit) ? ex_wea : '0;
  assign iwea = (rst && ex_valid && imem_hit && ex_pc_tag[2]) ? ex_wea : '0;

  assign iload_sel = rst & (pc_tag_m == BIOS_TAG);

  always_comb begin
    dload_sel = 2'd0;
    if (rst) begin
      if ((adr_tag_m & DMEM_TAG_MASK) == TAG_W'(1)) dload_sel = 2'd0;
      else if (adr_tag_m == BIOS_TAG)               dload_sel = 2'd1;
      else if (adr_tag_m == IO_TAG)                 dload_sel = 2'd2;
    end
  end

endmodule
